ethernet_tx_channel_arbiter: RTL and testbench

//  N-channel UDP TX front end. Sits ahead of the header-prepend path and merges NUM_CHANNELS user AXIS streams

---
 rtl/ethernet_tx_channel_arbiter.sv | 96 +++++++++
 tb/tb_ethernet_tx_channel_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/ethernet_tx_channel_arbiter.sv
// ethernet_tx_channel_arbiter: packet-level round-robin merge of N AXIS channels with per-packet metadata
module ethernet_tx_channel_arbiter #(
  parameter int DATA_WIDTH        = 512,
  parameter int CONN_ID_WIDTH     = 18,
  parameter int NUM_CHANNELS      = 4,
  parameter int LEN_WIDTH         = 16,
  parameter int MAX_PAYLOAD_BYTES = 1472
) (
  input  logic                                    tx_axis_aclk,
  input  logic                                    tx_axis_aresetn,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]      s_udp_tx_axis_tdata,
  input  logic [NUM_CHANNELS*DATA_WIDTH/8-1:0]    s_udp_tx_axis_tkeep,
  input  logic [NUM_CHANNELS-1:0]                 s_udp_tx_axis_tvalid,
  input  logic [NUM_CHANNELS-1:0]                 s_udp_tx_axis_tlast,
  input  logic [NUM_CHANNELS*CONN_ID_WIDTH-1:0]   s_udp_tx_axis_connection_id,
  output logic [NUM_CHANNELS-1:0]                 s_udp_tx_axis_tready,
  output logic [DATA_WIDTH-1:0]                   m_axis_tdata,
  output logic [DATA_WIDTH/8-1:0]                 m_axis_tkeep,
  output logic                                    m_axis_tlast,
  output logic                                    m_axis_tvalid,
  input  logic                                    m_axis_tready,
  output logic                                    m_meta_valid,
  input  logic                                    m_meta_ready,
  output logic [CONN_ID_WIDTH-1:0]                m_meta_connection_id,
  output logic [LEN_WIDTH-1:0]                    m_meta_length,
  output logic [$clog2(NUM_CHANNELS)-1:0]         m_meta_channel,
  output logic                                    m_meta_oversize
);
  localparam int CH_W = $clog2(NUM_CHANNELS);
  localparam int KW = DATA_WIDTH / 8;
  typedef enum logic [1:0] {IDLE, STREAM, META} state_t;
  state_t state;
  logic [CH_W-1:0] grant, last_grant, winner;
  logic [LEN_WIDTH-1:0] len, len_next;
  logic [LEN_WIDTH:0] sum;
  logic [CONN_ID_WIDTH-1:0] conn_lat, conn_cur;
  logic first, acc;
  always_comb begin
    winner = last_grant;
    // scan from farthest to nearest so the nearest valid channel after last_grant wins
    for (int i = NUM_CHANNELS; i >= 1; i--)
      if (s_udp_tx_axis_tvalid[(int'(last_grant) + i) % NUM_CHANNELS])
        winner = CH_W'((int'(last_grant) + i) % NUM_CHANNELS);
  end
  assign m_axis_tdata  = s_udp_tx_axis_tdata[grant*DATA_WIDTH +: DATA_WIDTH];
  assign m_axis_tkeep  = s_udp_tx_axis_tkeep[grant*KW +: KW];
  assign m_axis_tlast  = s_udp_tx_axis_tlast[grant];
  assign m_axis_tvalid = (state == STREAM) && s_udp_tx_axis_tvalid[grant];
  assign s_udp_tx_axis_tready = (state == STREAM && m_axis_tready) ? NUM_CHANNELS'(1) << grant : '0;
  assign conn_cur = s_udp_tx_axis_connection_id[grant*CONN_ID_WIDTH +: CONN_ID_WIDTH];
  assign acc      = m_axis_tvalid && m_axis_tready;
  assign sum      = {1'b0, len} + (LEN_WIDTH+1)'($countones(m_axis_tkeep));
  assign len_next = sum[LEN_WIDTH] ? '1 : sum[LEN_WIDTH-1:0];
  always_ff @(posedge tx_axis_aclk or negedge tx_axis_aresetn) begin
    if (!tx_axis_aresetn) begin
      state                <= IDLE;
      grant                <= '0;
      last_grant           <= CH_W'(NUM_CHANNELS - 1);
      len                  <= '0;
      first                <= 1'b0;
      conn_lat             <= '0;
      m_meta_valid         <= 1'b0;
      m_meta_connection_id <= '0;
      m_meta_length        <= '0;
      m_meta_channel       <= '0;
      m_meta_oversize      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (|s_udp_tx_axis_tvalid) begin
          grant      <= winner;
          last_grant <= winner;
          first      <= 1'b1;
          state      <= STREAM;
        end
        STREAM: if (acc) begin
          first <= 1'b0;
          if (first) conn_lat <= conn_cur;
          if (m_axis_tlast) begin
            m_meta_connection_id <= first ? conn_cur : conn_lat;
            m_meta_length        <= len_next;
            m_meta_channel       <= grant;
            m_meta_oversize      <= int'(len_next) > MAX_PAYLOAD_BYTES;
            m_meta_valid         <= 1'b1;
            len                  <= '0;
            state                <= META;
          end else len <= len_next;
        end
        META: if (m_meta_ready) begin
          m_meta_valid <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ethernet_tx_channel_arbiter.sv
// tb_ethernet_tx_channel_arbiter: table-driven packet vectors with a beat/meta scoreboard
module tb_ethernet_tx_channel_arbiter;
  localparam int DW = 512, KW = 64, CW = 18, N = 4, LW = 16;
  typedef struct {logic [DW-1:0] data; logic [KW-1:0] keep; logic last; logic [CW-1:0] conn;} beat_t;
  typedef struct {logic [CW-1:0] conn; logic [LW-1:0] len; logic [1:0] ch; logic ovs;} meta_t;
  typedef struct {int ch; int beats; logic [KW-1:0] lk; logic [CW-1:0] conn; int tmode; logic [LW-1:0] len; logic ovs;} vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [N*DW-1:0] s_tdata = '0;
  logic [N*KW-1:0] s_tkeep = '0;
  logic [N-1:0] s_tvalid = '0, s_tlast = '0, s_tready;
  logic [N*CW-1:0] s_conn = '0;
  logic [DW-1:0] m_tdata;
  logic [KW-1:0] m_tkeep;
  logic m_tlast, m_tvalid, m_tready = 1'b1;
  logic meta_valid, meta_ready = 1'b1, meta_ovs;
  logic [CW-1:0] meta_conn;
  logic [LW-1:0] meta_len;
  logic [1:0] meta_ch;
  beat_t chq[N][$];
  beat_t exp_beats[$];
  int exp_ch[$];
  meta_t exp_meta[$];
  int n_chk = 0, n_pass = 0, tmode = 0;
  logic stall = 1'b0;

  ethernet_tx_channel_arbiter dut (
    .tx_axis_aclk(clk), .tx_axis_aresetn(rst_n),
    .s_udp_tx_axis_tdata(s_tdata), .s_udp_tx_axis_tkeep(s_tkeep), .s_udp_tx_axis_tvalid(s_tvalid),
    .s_udp_tx_axis_tlast(s_tlast), .s_udp_tx_axis_connection_id(s_conn), .s_udp_tx_axis_tready(s_tready),
    .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast), .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready), .m_meta_valid(meta_valid), .m_meta_ready(meta_ready),
    .m_meta_connection_id(meta_conn), .m_meta_length(meta_len), .m_meta_channel(meta_ch),
    .m_meta_oversize(meta_ovs));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [599:0] act, input logic [599:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, req);
  endtask

  task automatic send(input int ch, input int beats, input logic [KW-1:0] lk, input logic [CW-1:0] conn,
                      input logic [LW-1:0] len, input logic ovs);
    beat_t x;
    meta_t m;
    for (int b = 0; b < beats; b++) begin
      for (int w = 0; w < DW/32; w++) x.data[w*32 +: 32] = $urandom;
      x.data[7:0] = 8'(ch);
      x.last = (b == beats - 1);
      x.keep = x.last ? lk : '1;
      x.conn = (b == 0) ? conn : CW'($urandom);
      chq[ch].push_back(x);
      exp_beats.push_back(x);
      exp_ch.push_back(ch);
    end
    m.conn = conn; m.len = len; m.ch = 2'(ch); m.ovs = ovs;
    exp_meta.push_back(m);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while ((exp_meta.size() > 0 || exp_beats.size() > 0) && k < budget) begin
      @(negedge clk);
      k++;
    end
    check("drain_left", exp_meta.size() + exp_beats.size(), 0);
  endtask

  // source driver and output monitor share one cycle loop so acceptance is seen exactly once
  initial begin
    logic [N-1:0] acc;
    beat_t e, h;
    meta_t em;
    int c;
    forever begin
      @(negedge clk);
      acc = s_tvalid & s_tready;
      if (m_tvalid && m_tready) begin
        if (exp_beats.size() == 0) check("unexpected_beat", 1, 0);
        else begin
          e = exp_beats.pop_front();
          c = exp_ch.pop_front();
          check("beat", {m_tlast, m_tkeep, m_tdata}, {e.last, e.keep, e.data});
          check("ready_onehot", s_tready, 1 << c);
        end
      end
      if (meta_valid && meta_ready) begin
        if (exp_meta.size() == 0) check("unexpected_meta", 1, 0);
        else begin
          em = exp_meta.pop_front();
          check("meta", {meta_conn, meta_len, meta_ch, meta_ovs}, {em.conn, em.len, em.ch, em.ovs});
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        if (acc[i] && chq[i].size() > 0) void'(chq[i].pop_front());
        s_tvalid[i] = chq[i].size() > 0 && !stall;
        if (chq[i].size() > 0) begin
          h = chq[i][0];
          s_tdata[i*DW +: DW] = h.data;
          s_tkeep[i*KW +: KW] = h.keep;
          s_tlast[i] = h.last;
          s_conn[i*CW +: CW] = h.conn;
        end
      end
      m_tready = (tmode != 0) ? ~m_tready : 1'b1;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[6];
    int k;
    vt[0] = '{0, 3,    64'hFF, 18'h155,   0, 16'd136,   1'b0};
    vt[1] = '{2, 5,    '1,     18'h2AA,   1, 16'd320,   1'b0};
    vt[2] = '{1, 24,   '1,     18'h30F0F, 0, 16'd1536,  1'b1};
    vt[3] = '{3, 1,    64'h1,  18'h3FFFF, 0, 16'd1,     1'b0};
    vt[4] = '{0, 23,   '1,     18'h01234, 0, 16'd1472,  1'b0};
    vt[5] = '{1, 1025, '1,     18'h2BCDE, 0, 16'hFFFF,  1'b1};
    repeat (3) @(posedge clk);
    #1;
    check("rst_tready", s_tready, 0);
    check("rst_tvalid", m_tvalid, 0);
    check("rst_meta_valid", meta_valid, 0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    // all channels loaded before the first arbitration: expected grant order 0,1,2,3,0
    for (int c = 0; c < N; c++) send(c, 1, '1, CW'(16 + c), 16'd64, 1'b0);
    send(0, 1, '1, 18'h20, 16'd64, 1'b0);
    drain(80);
    for (int i = 0; i < 6; i++) begin
      tmode = vt[i].tmode;
      send(vt[i].ch, vt[i].beats, vt[i].lk, vt[i].conn, vt[i].len, vt[i].ovs);
      drain(vt[i].beats * 3 + 20);
      tmode = 0;
    end
    // source stall mid-packet keeps the grant; ch2 wins over ch1 after last grant 1
    send(2, 4, '1, 18'h123, 16'd256, 1'b0);
    send(1, 1, '1, 18'h321, 16'd64, 1'b0);
    k = 0;
    while (exp_beats.size() > 3 && k < 40) begin @(negedge clk); k++; end
    stall = 1'b1;
    @(posedge clk);
    #2;
    repeat (4) begin
      @(negedge clk);
      check("stall_tvalid", m_tvalid, 0);
    end
    stall = 1'b0;
    drain(40);
    // meta back-pressure holds the record and blocks the next grant
    meta_ready = 1'b0;
    send(0, 2, '1, 18'h077, 16'd128, 1'b0);
    send(1, 1, '1, 18'h088, 16'd64, 1'b0);
    k = 0;
    while (!meta_valid && k < 30) begin @(negedge clk); k++; end
    check("meta_seen", meta_valid, 1);
    repeat (10) begin
      @(negedge clk);
      check("meta_hold", {meta_valid, meta_conn, meta_len, meta_ch, meta_ovs}, {1'b1, 18'h077, 16'd128, 2'd0, 1'b0});
      check("meta_hold_tready", s_tready, 0);
      check("meta_hold_tvalid", m_tvalid, 0);
    end
    @(posedge clk);
    #2 meta_ready = 1'b1;
    drain(40);
    // reset in the middle of a ch3 packet
    send(3, 8, '1, 18'h333, 16'd512, 1'b0);
    k = 0;
    while (exp_beats.size() > 5 && k < 40) begin @(negedge clk); k++; end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_tready", s_tready, 0);
    check("arst_tvalid", m_tvalid, 0);
    check("arst_meta_valid", meta_valid, 0);
    for (int c = 0; c < N; c++) chq[c].delete();
    exp_beats.delete();
    exp_ch.delete();
    exp_meta.delete();
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    send(0, 1, '1, 18'h0CD, 16'd64, 1'b0);
    send(3, 2, '1, 18'h3AB, 16'd128, 1'b0);
    drain(40);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
